// File: rtl/fsm_moore_sequence_tx.sv
// ---------------------------------------------------------------------------
// fsm_moore_sequence_tx
//
// Moore-style serial frame transmitter. A parallel payload is taken in over a
// valid/ready handshake and sent one bit per clock on o_data_out as
//   PREAMBLE (3 bits, bit 2 first) -> payload (MSB first) -> GAP_CYCLES zeros
// after which the block returns to IDLE and pulses o_frame_done for one cycle.
// The preamble gives a downstream "101" detector a fixed pattern to lock onto.
//
// State table
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   S_IDLE     | waiting for a payload, o_ready=1, line held at 0
//   S_PREAMBLE | sending PREAMBLE[2], [1], [0] (pre_cnt_q = 0,1,2)
//   S_DATA     | sending shift-register MSB, shifting left with 0 fill
//   S_GAP      | driving GAP_CYCLES zero bits before returning to IDLE
//
// Ports
//   i_clock      : system clock, all logic on the rising edge
//   i_reset      : synchronous reset, active-high, overrides everything
//   i_data       : payload word, latched only on an accepted handshake
//   i_valid      : payload present
//   o_ready      : block can accept a payload (IDLE only)
//   o_data_out   : registered serial bit stream
//   o_busy       : high in PREAMBLE, DATA and GAP
//   o_frame_done : one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module fsm_moore_sequence_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [2:0]  PREAMBLE   = 3'b101,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_data_out,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int unsigned BIT_CNT_W = ($clog2(DATA_WIDTH + 1) < 1) ? 1 : $clog2(DATA_WIDTH + 1);
  localparam int unsigned GAP_CNT_W = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  // Terminal-count values: the counters hold the index of the bit currently
  // on the line, so the last cycle of a state is reached at COUNT-1.
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_GAP      = 2'd3
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic [1:0]              pre_cnt_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_d;
  logic [GAP_CNT_W-1:0]    gap_cnt_q;
  logic [GAP_CNT_W-1:0]    gap_cnt_d;
  logic                    data_out_q;
  logic                    frame_done_q;

  always_comb begin
    shift_d   = shift_q << 1;
    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
  end

  // The line value is registered together with the state transition, so
  // data_out_q always carries the bit belonging to the state being entered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      pre_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      data_out_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          data_out_q <= 1'b0;
          if (i_valid) begin
            state_q    <= S_PREAMBLE;
            shift_q    <= i_data;
            pre_cnt_q  <= 2'd0;
            data_out_q <= PREAMBLE[2];
          end
        end

        S_PREAMBLE: begin
          if (pre_cnt_q == 2'd2) begin
            state_q    <= S_DATA;
            bit_cnt_q  <= '0;
            data_out_q <= shift_q[DATA_WIDTH-1];
            shift_q    <= shift_d;
          end else begin
            pre_cnt_q  <= pre_cnt_q + 2'd1;
            data_out_q <= (pre_cnt_q == 2'd0) ? PREAMBLE[1] : PREAMBLE[0];
          end
        end

        S_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            data_out_q <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q      <= S_IDLE;
              frame_done_q <= 1'b1;
            end else begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
            end
          end else begin
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= shift_q[DATA_WIDTH-1];
            shift_q    <= shift_d;
          end
        end

        S_GAP: begin
          data_out_q <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            state_q      <= S_IDLE;
            frame_done_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          data_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_data_out   = data_out_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fsm_moore_sequence_tx.sv
module tb_fsm_moore_sequence_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid8, valid4;
  logic [7:0] data8;
  logic [3:0] data4;
  logic       ready8, o8, busy8, done8;
  logic       ready4, o4, busy4, done4;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  fsm_moore_sequence_tx #(.DATA_WIDTH(8), .PREAMBLE(3'b101), .GAP_CYCLES(2)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_data(data8), .i_valid(valid8),
    .o_ready(ready8), .o_data_out(o8), .o_busy(busy8), .o_frame_done(done8)
  );

  fsm_moore_sequence_tx #(.DATA_WIDTH(4), .PREAMBLE(3'b101), .GAP_CYCLES(0)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_data(data4), .i_valid(valid4),
    .o_ready(ready4), .o_data_out(o4), .o_busy(busy4), .o_frame_done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each accepted frame becomes a list of per-cycle
  // expectations {done, busy, out}; an empty list means idle.
  typedef logic [2:0] ent_t;
  typedef ent_t eq_t[$];

  function automatic eq_t build_frame(int w, int gap, logic [31:0] d);
    eq_t        q;
    logic [2:0] pre;
    pre = 3'b101;
    q = {};
    for (int i = 2; i >= 0; i--) q.push_back({2'b01, pre[i]});
    for (int i = w - 1; i >= 0; i--) q.push_back({2'b01, d[i]});
    for (int i = 0; i < gap; i++) q.push_back(3'b010);
    q.push_back(3'b100);
    return q;
  endfunction

  eq_t  q8, q4;
  ent_t cur8 = 3'b000;
  ent_t cur4 = 3'b000;

  always @(posedge clk) begin
    if (rst) begin
      q8.delete(); q4.delete();
      cur8 = 3'b000; cur4 = 3'b000;
    end else begin
      if (valid8 && !cur8[1]) q8 = build_frame(8, 2, 32'(data8));
      if (valid4 && !cur4[1]) q4 = build_frame(4, 0, 32'(data4));
      cur8 = (q8.size() > 0) ? q8.pop_front() : 3'b000;
      cur4 = (q4.size() > 0) ? q4.pop_front() : 3'b000;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_out",   32'(o8),     32'(cur8[0]));
      chk("m8_busy",  32'(busy8),  32'(cur8[1]));
      chk("m8_ready", 32'(ready8), 32'(!cur8[1]));
      chk("m8_done",  32'(done8),  32'(cur8[2]));
      chk("m4_out",   32'(o4),     32'(cur4[0]));
      chk("m4_busy",  32'(busy4),  32'(cur4[1]));
      chk("m4_ready", 32'(ready4), 32'(!cur4[1]));
      chk("m4_done",  32'(done4),  32'(cur4[2]));
    end
  end

  // Loopback "101" detector (overlapping) on the 8-bit transmitter line.
  bit         det_en = 1'b0;
  logic [2:0] hist   = 3'b000;
  int         det_cnt = 0;
  always @(negedge clk) begin
    if (det_en) begin
      hist = {hist[1:0], o8};
      if (hist == 3'b101) det_cnt++;
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready8 && ready4 && !done8 && !done4) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [12:0] seq8;
  logic [6:0]  seq4;
  bit          busy_all, done_any;
  int          s1, s2, ready_mid, rises;
  bit          prev_busy;

  initial begin
    rst = 1'b1; valid8 = 1'b0; valid4 = 1'b0; data8 = '0; data4 = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy",  32'(busy8),  32'd0);
    chk("rst_out",   32'(o8),     32'd0);
    chk("rst_done",  32'(done8),  32'd0);

    // Single frame 8'hC5 with defaults
    @(negedge clk); valid8 = 1'b1; data8 = 8'hC5;
    @(negedge clk); valid8 = 1'b0; data8 = 8'($urandom);
    busy_all = 1'b1; done_any = 1'b0;
    for (int i = 0; i < 13; i++) begin
      seq8[12-i] = o8; busy_all &= busy8; done_any |= done8;
      @(negedge clk);
    end
    chk("t1_seq",     32'(seq8),     32'(13'b1011100010100));
    chk("t1_busy",    32'(busy_all), 32'd1);
    chk("t1_no_done", 32'(done_any), 32'd0);
    chk("t1_done",    32'(done8),    32'd1);
    @(negedge clk);
    chk("t1_done_once", 32'(done8), 32'd0);

    // DATA_WIDTH=4, no gap, 4'h9
    @(negedge clk); valid4 = 1'b1; data4 = 4'h9;
    @(negedge clk); valid4 = 1'b0; data4 = 4'h6;
    done_any = 1'b0;
    for (int i = 0; i < 7; i++) begin
      seq4[6-i] = o4; done_any |= done4;
      @(negedge clk);
    end
    chk("t4_seq",     32'(seq4),     32'(7'b1011001));
    chk("t4_no_done", 32'(done_any), 32'd0);
    chk("t4_done",    32'(done4),    32'd1);
    wait_idle();

    // Back-to-back FF then 00 with valid held high
    @(negedge clk); valid8 = 1'b1; data8 = 8'hFF;
    s1 = -1; s2 = -1; ready_mid = 0; prev_busy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy8 && !prev_busy) begin
        if (s1 < 0) begin s1 = c; data8 = 8'h00; end
        else begin s2 = c; valid8 = 1'b0; end
      end else if (s1 >= 0 && s2 < 0 && ready8) begin
        ready_mid++;
      end
      prev_busy = busy8;
      if (s2 >= 0) break;
    end
    valid8 = 1'b0;
    chk("b2b_spacing", 32'(s2 - s1), 32'd14);
    chk("b2b_ready",   32'(ready_mid), 32'd1);
    wait_idle();

    // Reset during data bit 3 of 8'hA5
    @(negedge clk); valid8 = 1'b1; data8 = 8'hA5;
    @(negedge clk); valid8 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mr_out",   32'(o8),     32'd0);
    chk("mr_busy",  32'(busy8),  32'd0);
    chk("mr_ready", 32'(ready8), 32'd1);
    done_any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      done_any |= done8;
    end
    chk("mr_no_done", 32'(done_any), 32'd0);

    // Loopback: three back-to-back zero payloads give one hit per preamble
    hist = 3'b000; det_cnt = 0; det_en = 1'b1;
    @(negedge clk); valid8 = 1'b1; data8 = 8'h00;
    rises = 0; prev_busy = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy8 && !prev_busy) rises++;
      prev_busy = busy8;
      if (rises == 3) break;
    end
    valid8 = 1'b0;
    chk("lb_frames", 32'(rises), 32'd3);
    wait_idle();
    repeat (3) @(negedge clk);
    det_en = 1'b0;
    chk("lb_detect", 32'(det_cnt), 32'd3);

    // Randomized traffic with hold-off toggling and rare resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      valid8 = 1'($urandom_range(0, 1));
      data8  = 8'($urandom);
      valid4 = 1'($urandom_range(0, 1));
      data4  = 4'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; valid8 = 1'b0; valid4 = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
